// File: rtl/tiny16_pkg.sv
// Shared definitions for the tiny16 datapath: bus width, requester ids and
// the bus arbiter state encoding.
package tiny16_pkg;

    localparam int BUS_WIDTH  = 16;
    localparam int HOLD_CNT_W = 4;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_REG = 2;
    localparam int REQ_CTL = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority encoder: the first set request at or after rr_ptr_i,
// scanning upward and wrapping, wins.
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_masked_i,
    input  logic [IDW-1:0]   rr_ptr_i,
    output logic [IDW-1:0]   winner_o,
    output logic             any_o
);

    always_comb begin
        // NOTE: every output gets a value before the loop, so no latch is inferred.
        winner_o = '0;
        any_o    = 1'b0;
        // Scan from the farthest offset down so the nearest set bit is written last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(rr_ptr_i) + i) % N_REQ;
            if (req_masked_i[idx]) begin
                winner_o = IDW'(idx);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Registered round-robin owner of the shared datapath bus, with bounded
// multi-cycle locking and a zero-latency output mux behind the grant.
module bus_arbiter
    import tiny16_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = BUS_WIDTH,
    parameter int HOLD_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           lock,
    input  logic [N_REQ*WIDTH-1:0]     in_data,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid
);

    localparam int IDW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0]      ONE      = N_REQ'(1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_TOP = HOLD_CNT_W'(HOLD_MAX - 1);

    arb_state_e            state_q;
    logic [N_REQ-1:0]      gnt_q;
    logic [IDW-1:0]        gnt_id_q;
    logic [IDW-1:0]        rr_ptr_q;
    logic [HOLD_CNT_W-1:0] hold_cnt_q;

    logic             lock_hit;
    logic             at_limit;
    logic [N_REQ-1:0] req_masked;
    logic [IDW-1:0]   pick_winner;
    logic             pick_any;

    assign lock_hit   = (state_q != ARB_IDLE) && req[gnt_id_q] && lock[gnt_id_q];
    assign at_limit   = (hold_cnt_q == HOLD_TOP);
    // An expired lock takes its holder out of the running for one decision.
    assign req_masked = (lock_hit && at_limit) ? (req & ~(ONE << gnt_id_q)) : req;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req_masked_i (req_masked),
        .rr_ptr_i     (rr_ptr_q),
        .winner_o     (pick_winner),
        .any_o        (pick_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
        end else if (lock_hit && !at_limit) begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            state_q    <= ARB_LOCKED;
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end else if (pick_any) begin
            state_q    <= ARB_GRANT;
            gnt_q      <= ONE << pick_winner;
            gnt_id_q   <= pick_winner;
            rr_ptr_q   <= (pick_winner == IDW'(N_REQ - 1)) ? '0 : pick_winner + 1'b1;
            hold_cnt_q <= '0;
        end else if (lock_hit) begin
            // Expired lock with no competitor: same holder, fresh lock window.
            state_q    <= ARB_GRANT;
            rr_ptr_q   <= (gnt_id_q == IDW'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            hold_cnt_q <= '0;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;

    always_comb begin
        out       = '0;
        out_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i] && req[i]) begin
                out       = in_data[i*WIDTH +: WIDTH];
                out_valid = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: an abstract holder/pointer model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int HM = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   lock = '0;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   gnt;
    logic [1:0]     gnt_id;
    logic [W-1:0]   bus_out;
    logic           out_valid;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_MAX(HM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .in_data   (in_data),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .out       (bus_out),
        .out_valid (out_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic expect_bus(input string name, input logic [3:0] g, input logic [1:0] id,
                              input logic [15:0] o, input logic v);
        check($sformatf("%s.gnt", name), 32'(gnt), 32'(g));
        check($sformatf("%s.gnt_id", name), 32'(gnt_id), 32'(id));
        check($sformatf("%s.out", name), 32'(bus_out), 32'(o));
        check($sformatf("%s.out_valid", name), 32'(out_valid), 32'(v));
    endtask

    // Model: who holds the bus, where the search starts, how long the lock has run.
    int m_holder = -1;
    int m_ptr    = 0;
    int m_streak = 0;
    int nx_holder, nx_ptr, nx_streak;

    always_comb begin
        int excl;
        nx_holder = -1;
        nx_ptr    = m_ptr;
        nx_streak = 0;
        excl      = -1;
        if (m_holder >= 0 && req[m_holder] && lock[m_holder] && m_streak < HM - 1) begin
            nx_holder = m_holder;
            nx_streak = m_streak + 1;
        end else begin
            if (m_holder >= 0 && req[m_holder] && lock[m_holder]) excl = m_holder;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (nx_holder < 0 && req[c] && c != excl) nx_holder = c;
            end
            if (nx_holder < 0 && excl >= 0) nx_holder = excl;
            if (nx_holder >= 0) nx_ptr = (nx_holder + 1) % N;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_holder <= -1;
            m_ptr    <= 0;
            m_streak <= 0;
        end else begin
            m_holder <= nx_holder;
            m_ptr    <= nx_ptr;
            m_streak <= nx_streak;
        end
    end

    always @(negedge clk) begin
        logic [3:0]  e_gnt;
        logic [1:0]  e_id;
        logic [15:0] e_out;
        logic        e_v;
        e_gnt = '0;
        e_id  = '0;
        e_out = '0;
        e_v   = 1'b0;
        if (m_holder >= 0) begin
            e_gnt[m_holder] = 1'b1;
            e_id = 2'(m_holder);
            if (req[m_holder]) begin
                e_v   = 1'b1;
                e_out = in_data[m_holder*W +: W];
            end
        end
        expect_bus("model", e_gnt, e_id, e_out, e_v);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req  = '0;
        lock = '0;
        rst  = 1'b0;
        tick();
        tick();
        rst  = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_data = {16'hC0DE, 16'hBEEF, 16'h1234, 16'hA1A1};
        #2;
        expect_bus("reset", 4'b0000, 2'd0, 16'h0000, 1'b0);

        // Single request, re-granted every cycle while held.
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_bus("single", 4'b0100, 2'd2, 16'hBEEF, 1'b1);
        end

        // Round-robin over four constant requesters.
        do_reset();
        req = 4'b1111;
        tick(); expect_bus("rr0", 4'b0001, 2'd0, 16'hA1A1, 1'b1);
        tick(); expect_bus("rr1", 4'b0010, 2'd1, 16'h1234, 1'b1);
        tick(); expect_bus("rr2", 4'b0100, 2'd2, 16'hBEEF, 1'b1);
        tick(); expect_bus("rr3", 4'b1000, 2'd3, 16'hC0DE, 1'b1);
        tick(); expect_bus("rr4", 4'b0001, 2'd0, 16'hA1A1, 1'b1);

        // Lock limit: four cycles for 0, one forced turn for 3, back to 0.
        do_reset();
        req  = 4'b1001;
        lock = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_bus("lock_hold", 4'b0001, 2'd0, 16'hA1A1, 1'b1);
        end
        tick(); expect_bus("lock_release", 4'b1000, 2'd3, 16'hC0DE, 1'b1);
        tick(); expect_bus("lock_return", 4'b0001, 2'd0, 16'hA1A1, 1'b1);

        // Lone locked requester is re-granted after its window expires.
        do_reset();
        req  = 4'b0010;
        lock = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_bus("lock_alone", 4'b0010, 2'd1, 16'h1234, 1'b1);
        end

        // Holder drops req: grant stays, transfer stops at once.
        do_reset();
        req = 4'b0010;
        tick(); expect_bus("drop_pre", 4'b0010, 2'd1, 16'h1234, 1'b1);
        req = 4'b0100;
        #1;     expect_bus("drop_now", 4'b0010, 2'd1, 16'h0000, 1'b0);
        tick(); expect_bus("drop_next", 4'b0100, 2'd2, 16'hBEEF, 1'b1);
        req = 4'b0000;
        tick(); expect_bus("drop_idle", 4'b0000, 2'd0, 16'h0000, 1'b0);

        // Asynchronous reset in the middle of a lock.
        do_reset();
        req  = 4'b1000;
        lock = 4'b1000;
        tick(); tick(); tick();
        expect_bus("lock3", 4'b1000, 2'd3, 16'hC0DE, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        expect_bus("async_rst", 4'b0000, 2'd0, 16'h0000, 1'b0);
        req  = 4'b1111;
        lock = 4'b0000;
        tick();
        expect_bus("rst_held", 4'b0000, 2'd0, 16'h0000, 1'b0);
        rst = 1'b1;
        tick(); expect_bus("post_rst", 4'b0001, 2'd0, 16'hA1A1, 1'b1);

        // Idle stretch leaves the rotation pointer where it was.
        do_reset();
        req = 4'b0010;
        tick(); expect_bus("idle_setup", 4'b0010, 2'd1, 16'h1234, 1'b1);
        req  = 4'b0000;
        lock = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_bus("idle", 4'b0000, 2'd0, 16'h0000, 1'b0);
        end
        lock = 4'b0000;
        req  = 4'b1111;
        tick(); expect_bus("idle_resume", 4'b0100, 2'd2, 16'hBEEF, 1'b1);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Registered round-robin arbiter that owns the shared 16-bit datapath bus. It replaces the hard-wired out_en fan-in with a request/grant handshake between the four bus sources: ALU, memory, register file and controller. Each cycle it grants the bus to exactly one requester or to none, drives the granted source's data onto out, and supports bounded multi-cycle bus locking for instruction sequences that must not be interleaved.

Parameters:
N_REQ, 4, number of requesters; requester id = index.
WIDTH, 16, bus data width.
HOLD_MAX, 4, maximum consecutive cycles one locked requester may keep the bus (range 1..15).

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset.
req  in  N_REQ  per-requester bus request; level-sensitive.
lock  in  N_REQ  per-requester request to keep the grant next cycle; ignored unless matching req is high.
in_data  in  N_REQ*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH].
gnt  out  N_REQ  one-hot registered grant (all zero = bus idle).
gnt_id  out  2  index of current grant holder; 0 when idle.
out  out  WIDTH  bus value: in_data of the granted requester, else 0.
out_valid  out  1  high when a grant is held and the holder's req is still high (a transfer happens this cycle).

Behaviour:
- Reset (rst low, async): gnt=0, gnt_id=0, out=0, out_valid=0, rr_ptr=0, hold_cnt=0, state=IDLE. Takes effect immediately, including mid-lock. The first post-reset arbitration favours requester 0.
- States: IDLE (no grant), GRANT (single-cycle grant), LOCKED (grant extended by lock).
- Arbitration happens at each rising edge from the current req/lock and state. Latency: req high in cycle t gives gnt in cycle t+1 at the earliest.
- Priority is rotating: search req starting at index rr_ptr, ascending, mod N_REQ. First set bit wins. On every new grant to k, rr_ptr <= (k+1) mod N_REQ.
- GRANT/LOCKED holder h, next-edge decision:
  - req[h]&lock[h] and hold_cnt < HOLD_MAX-1: keep h; state LOCKED; hold_cnt++.
  - req[h]&lock[h] and hold_cnt == HOLD_MAX-1: forced release. Re-arbitrate with h masked out. If no other requester, h is re-granted and hold_cnt restarts at 0.
  - Otherwise: normal re-arbitration with h eligible at its rotated position; hold_cnt=0.
- No requester: state IDLE, gnt=0; rr_ptr unchanged.
- A holder that drops req while granted keeps gnt for that cycle, but out_valid=0 and out=0. The grant is released at the next edge.
- out and out_valid are combinational from the registered gnt and the current req/in_data: zero added latency once granted.
- gnt is always one-hot or zero. gnt_id is consistent with gnt.
- hold_cnt width is 4 bits; it never exceeds HOLD_MAX-1.
- lock asserted with req low: ignored. lock on a non-holder has no effect on arbitration.

Decomposition:
- Shared package tiny16_pkg holds: BUS_WIDTH=16; requester ids REQ_ALU=0, REQ_MEM=1, REQ_REG=2, REQ_CTL=3; arbiter state enum {ARB_IDLE, ARB_GRANT, ARB_LOCKED}.
- One sub-module: rr_pick. Purely combinational rotate-priority encoder with inputs (req_masked, rr_ptr) and outputs (winner index, any). It is instantiated once.
- bus_arbiter keeps the state register, rr_ptr, hold_cnt and the output mux.

Test Plan:
- Single request: req=0100 held from cycle 1, in_data[2]=16'hBEEF -> cycle 2 gnt=0100, gnt_id=2, out=BEEF, out_valid=1. It is re-granted every cycle while held.
- Round-robin: after reset req=1111 held, no lock -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles.
- Lock limit: HOLD_MAX=4, req=1001, lock=0001 held -> gnt=0001 for 4 consecutive cycles, then 1000 for one cycle, then 0001 again.
- Drop mid-grant: requester 1 granted, req[1] falls -> same cycle out_valid=0, out=0. Next cycle gnt=0 (or the next requester).
- Reset mid-lock: requester 3 locked at hold_cnt=2, rst low asynchronously -> gnt=0, out=0, out_valid=0 immediately. After release with req=1111, the first grant goes to requester 0.
- Idle: req=0 for 10 cycles -> gnt=0, gnt_id=0, out=0, out_valid=0 throughout; rr_ptr unchanged on the next grant.
